// File: rtl/swervolf_btn_debounce.sv
// Board pushbutton front end: two-flop synchronizer, per-button counter debouncer
// and sticky rise/fall event flags that feed the system controller's GPIO readback and IRQ.
module swervolf_btn_debounce #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_BTN-1:0] i_btn,
  input  logic [N_BTN-1:0] i_rise_en,
  input  logic [N_BTN-1:0] i_fall_en,
  input  logic             i_clr_stb,
  input  logic [N_BTN-1:0] i_clr_mask,
  output logic [N_BTN-1:0] o_btn,
  output logic [N_BTN-1:0] o_pend,
  output logic             o_irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;
  logic [N_BTN-1:0] btn_q;
  logic [N_BTN-1:0] btn_d;
  logic [N_BTN-1:0] pend_q;
  logic [N_BTN-1:0] pend_d;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];
  logic [N_BTN-1:0] evt;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;

  // The counter tracks consecutive samples disagreeing with the accepted level;
  // the first agreeing sample throws the partial count away.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    btn_d = btn_q;
    evt   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == btn_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        btn_d[i] = sync2_q[i];
        cnt_d[i] = '0;
        evt[i]   = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // sync2 already holds the newly accepted level in the cycle evt fires.
  assign rise = evt & sync2_q & i_rise_en;
  assign fall = evt & ~sync2_q & i_fall_en;

  // Set is OR-ed in after the clear so a same-cycle event is never lost.
  always_comb begin
    pend_d = (pend_q & ~({N_BTN{i_clr_stb}} & i_clr_mask)) | rise | fall;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of the others, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      btn_q   <= '0;
      pend_q  <= '0;
      // NOTE: the counter array is ordinary flops, not a RAM, and must be reset so
      // a reset mid-debounce aborts the count.
      cnt_q   <= '{default: '0};
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
      btn_q   <= btn_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_btn  = btn_q;
  assign o_pend = pend_q;
  assign o_irq  = |pend_q;

endmodule

// File: tb/tb_swervolf_btn_debounce.sv
// Self-checking bench for swervolf_btn_debounce with DEBOUNCE_CYCLES = 4, N_BTN = 5.
// Each scenario queues the expected outputs as it drives an edge and compares one cycle later.
module tb_swervolf_btn_debounce;

  localparam int N_BTN = 5;
  localparam int DC    = 4;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic [N_BTN-1:0] i_btn;
  logic [N_BTN-1:0] i_rise_en;
  logic [N_BTN-1:0] i_fall_en;
  logic             i_clr_stb;
  logic [N_BTN-1:0] i_clr_mask;
  logic [N_BTN-1:0] o_btn;
  logic [N_BTN-1:0] o_pend;
  logic             o_irq;

  typedef struct {
    string            name;
    logic [N_BTN-1:0] btn;
    logic [N_BTN-1:0] pend;
    logic             irq;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  swervolf_btn_debounce #(
    .N_BTN          (N_BTN),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_btn     (i_btn),
    .i_rise_en (i_rise_en),
    .i_fall_en (i_fall_en),
    .i_clr_stb (i_clr_stb),
    .i_clr_mask(i_clr_mask),
    .o_btn     (o_btn),
    .o_pend    (o_pend),
    .o_irq     (o_irq)
  );

  always #5 i_clk = ~i_clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    exp_t e;
    i_rst      = 1'b1;
    i_btn      = 5'h1F;
    i_rise_en  = 5'h1F;
    i_fall_en  = 5'h00;
    i_clr_stb  = 1'b0;
    i_clr_mask = 5'h00;
    for (int k = 1; k <= 9; k++) begin
      if (k == 4) i_rst = 1'b0;
      if (k <= 3)
        sb.push_back('{name: $sformatf("reset_hold_%0d", k), btn: 5'h00, pend: 5'h00, irq: 1'b0});
      else
        sb.push_back('{name: $sformatf("reset_release_e%0d", k - 3),
                       btn: (k == 9) ? 5'h1F : 5'h00, pend: (k == 9) ? 5'h1F : 5'h00, irq: (k == 9)});
      tick();
      e = sb.pop_front();
      n_vec++;
      if (o_btn !== e.btn || o_pend !== e.pend || o_irq !== e.irq) begin
        n_err++;
        $display("FAIL %s: got btn=%h pend=%h irq=%b, expected btn=%h pend=%h irq=%b",
                 e.name, o_btn, o_pend, o_irq, e.btn, e.pend, e.irq);
      end
    end
    i_clr_stb  = 1'b1;
    i_clr_mask = 5'h1F;
    sb.push_back('{name: "reset_clear_all", btn: 5'h1F, pend: 5'h00, irq: 1'b0});
    tick();
    e = sb.pop_front();
    n_vec++;
    if (o_btn !== e.btn || o_pend !== e.pend || o_irq !== e.irq) begin
      n_err++;
      $display("FAIL %s: got btn=%h pend=%h irq=%b, expected btn=%h pend=%h irq=%b",
               e.name, o_btn, o_pend, o_irq, e.btn, e.pend, e.irq);
    end
    i_clr_stb  = 1'b0;
    i_clr_mask = 5'h00;
    i_btn      = 5'h00;
    i_rise_en  = 5'h00;
    idle(10);
  endtask

  // A 3-sample pulse is rejected; a 4-sample pulse is accepted and then falls
  // back exactly DC edges later.
  task automatic test_glitch(input logic en2);
    exp_t e;
    i_rise_en = en2 ? 5'h1F : 5'h1B;
    i_fall_en = 5'h00;
    for (int k = 1; k <= 21; k++) begin
      if (k <= 11) begin
        i_btn = (k <= 3) ? 5'h04 : 5'h00;
        sb.push_back('{name: $sformatf("glitch3_en%0d_e%0d", en2, k), btn: 5'h00, pend: 5'h00, irq: 1'b0});
      end else begin
        i_btn = (k - 11 <= 4) ? 5'h04 : 5'h00;
        sb.push_back('{name: $sformatf("pulse4_en%0d_e%0d", en2, k - 11),
                       btn:  (k - 11 >= 6 && k - 11 <= 9) ? 5'h04 : 5'h00,
                       pend: (en2 && k - 11 >= 6) ? 5'h04 : 5'h00,
                       irq:  (en2 && k - 11 >= 6)});
      end
      tick();
      e = sb.pop_front();
      n_vec++;
      if (o_btn !== e.btn || o_pend !== e.pend || o_irq !== e.irq) begin
        n_err++;
        $display("FAIL %s: got btn=%h pend=%h irq=%b, expected btn=%h pend=%h irq=%b",
                 e.name, o_btn, o_pend, o_irq, e.btn, e.pend, e.irq);
      end
    end
    i_clr_stb  = 1'b1;
    i_clr_mask = 5'h04;
    tick();
    i_clr_stb  = 1'b0;
    i_clr_mask = 5'h00;
    idle(2);
  endtask

  task automatic test_fall();
    exp_t e;
    i_rise_en = 5'h00;
    i_fall_en = 5'h01;
    for (int k = 1; k <= 16; k++) begin
      i_btn = (k <= 8) ? 5'h01 : 5'h00;
      sb.push_back('{name: $sformatf("fall_e%0d", k),
                     btn:  (k >= 6 && k <= 13) ? 5'h01 : 5'h00,
                     pend: (k >= 14) ? 5'h01 : 5'h00,
                     irq:  (k >= 14)});
      tick();
      e = sb.pop_front();
      n_vec++;
      if (o_btn !== e.btn || o_pend !== e.pend || o_irq !== e.irq) begin
        n_err++;
        $display("FAIL %s: got btn=%h pend=%h irq=%b, expected btn=%h pend=%h irq=%b",
                 e.name, o_btn, o_pend, o_irq, e.btn, e.pend, e.irq);
      end
    end
  endtask

  // Starts with pend = 01 left by test_fall; button 4 adds bit 4.
  task automatic test_clear_mask();
    exp_t e;
    i_rise_en = 5'h10;
    i_fall_en = 5'h00;
    for (int k = 1; k <= 17; k++) begin
      i_btn      = (k <= 8) ? 5'h10 : 5'h00;
      i_clr_stb  = (k >= 16);
      i_clr_mask = (k == 15) ? 5'h1F : (k == 16) ? 5'h01 : (k == 17) ? 5'h10 : 5'h00;
      sb.push_back('{name: $sformatf("clear_mask_e%0d", k),
                     btn:  (k >= 6 && k <= 13) ? 5'h10 : 5'h00,
                     pend: (k == 17) ? 5'h00 : (k == 16) ? 5'h10 : (k >= 6) ? 5'h11 : 5'h01,
                     irq:  (k != 17)});
      tick();
      e = sb.pop_front();
      n_vec++;
      if (o_btn !== e.btn || o_pend !== e.pend || o_irq !== e.irq) begin
        n_err++;
        $display("FAIL %s: got btn=%h pend=%h irq=%b, expected btn=%h pend=%h irq=%b",
                 e.name, o_btn, o_pend, o_irq, e.btn, e.pend, e.irq);
      end
    end
    i_clr_stb  = 1'b0;
    i_clr_mask = 5'h00;
  endtask

  // Clear strobe lands on the rise-event edge (6) and again on edge 7.
  task automatic test_set_wins();
    exp_t e;
    i_rise_en  = 5'h08;
    i_fall_en  = 5'h00;
    i_btn      = 5'h08;
    i_clr_mask = 5'h08;
    for (int k = 1; k <= 8; k++) begin
      i_clr_stb = (k == 6 || k == 7);
      sb.push_back('{name: $sformatf("set_wins_e%0d", k),
                     btn:  (k >= 6) ? 5'h08 : 5'h00,
                     pend: (k == 6) ? 5'h08 : 5'h00,
                     irq:  (k == 6)});
      tick();
      e = sb.pop_front();
      n_vec++;
      if (o_btn !== e.btn || o_pend !== e.pend || o_irq !== e.irq) begin
        n_err++;
        $display("FAIL %s: got btn=%h pend=%h irq=%b, expected btn=%h pend=%h irq=%b",
                 e.name, o_btn, o_pend, o_irq, e.btn, e.pend, e.irq);
      end
    end
    i_clr_stb  = 1'b0;
    i_clr_mask = 5'h00;
    i_btn      = 5'h00;
    i_rise_en  = 5'h00;
    idle(8);
  endtask

  // Button 1 would qualify on edge 6; reset on edge 5 restarts the whole chain.
  task automatic test_reset_mid();
    exp_t e;
    i_rise_en = 5'h02;
    i_fall_en = 5'h00;
    i_btn     = 5'h02;
    for (int k = 1; k <= 12; k++) begin
      i_rst = (k == 5);
      sb.push_back('{name: $sformatf("reset_mid_e%0d", k),
                     btn:  (k >= 11) ? 5'h02 : 5'h00,
                     pend: (k >= 11) ? 5'h02 : 5'h00,
                     irq:  (k >= 11)});
      tick();
      e = sb.pop_front();
      n_vec++;
      if (o_btn !== e.btn || o_pend !== e.pend || o_irq !== e.irq) begin
        n_err++;
        $display("FAIL %s: got btn=%h pend=%h irq=%b, expected btn=%h pend=%h irq=%b",
                 e.name, o_btn, o_pend, o_irq, e.btn, e.pend, e.irq);
      end
    end
    i_rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_glitch(1'b1);
    test_glitch(1'b0);
    test_fall();
    test_clear_mask();
    test_set_wins();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
